// File: rtl/kbd_pkg.sv
// Shared scan-code constants, event bit positions and decoder FSM states.
// Purely declarative: no logic, no latency.
// No flow control here.
package kbd_pkg;

   // PS/2 set-2 prefix and modifier scan codes
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   // Bit positions inside one key event word
   localparam int EVT_BRK   = 15;
   localparam int EVT_EXT   = 14;
   localparam int EVT_SHIFT = 13;
   localparam int EVT_CTRL  = 12;
   localparam int EVT_CAPS  = 11;
   localparam int EVT_UNMAP = 10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_DEC
   } state_t;

   // Keyboard housekeeping bytes (self-test, ack, resend, overrun) carry no key
   function automatic logic is_dropped(input logic [7:0] code);
      return code inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
   endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// Maps a non-extended set-2 make code to ASCII (letters, digits, a few controls).
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
module scancode_to_ascii (
   input  logic [7:0] code,
   input  logic       upper,
   output logic [7:0] ascii,
   output logic       mapped
);

   logic [7:0] lc;

   // Letters resolve to lowercase first and are shifted to uppercase afterwards
   always_comb begin
      lc     = 8'h00;
      ascii  = code;
      mapped = 1'b0;
      case (code)
         8'h1C: lc = 8'h61;
         8'h32: lc = 8'h62;
         8'h21: lc = 8'h63;
         8'h23: lc = 8'h64;
         8'h24: lc = 8'h65;
         8'h2B: lc = 8'h66;
         8'h34: lc = 8'h67;
         8'h33: lc = 8'h68;
         8'h43: lc = 8'h69;
         8'h3B: lc = 8'h6A;
         8'h42: lc = 8'h6B;
         8'h4B: lc = 8'h6C;
         8'h3A: lc = 8'h6D;
         8'h31: lc = 8'h6E;
         8'h44: lc = 8'h6F;
         8'h4D: lc = 8'h70;
         8'h15: lc = 8'h71;
         8'h2D: lc = 8'h72;
         8'h1B: lc = 8'h73;
         8'h2C: lc = 8'h74;
         8'h3C: lc = 8'h75;
         8'h2A: lc = 8'h76;
         8'h1D: lc = 8'h77;
         8'h22: lc = 8'h78;
         8'h35: lc = 8'h79;
         8'h1A: lc = 8'h7A;
         8'h45: begin ascii = 8'h30; mapped = 1'b1; end
         8'h16: begin ascii = 8'h31; mapped = 1'b1; end
         8'h1E: begin ascii = 8'h32; mapped = 1'b1; end
         8'h26: begin ascii = 8'h33; mapped = 1'b1; end
         8'h25: begin ascii = 8'h34; mapped = 1'b1; end
         8'h2E: begin ascii = 8'h35; mapped = 1'b1; end
         8'h36: begin ascii = 8'h36; mapped = 1'b1; end
         8'h3D: begin ascii = 8'h37; mapped = 1'b1; end
         8'h3E: begin ascii = 8'h38; mapped = 1'b1; end
         8'h46: begin ascii = 8'h39; mapped = 1'b1; end
         8'h29: begin ascii = 8'h20; mapped = 1'b1; end
         8'h5A: begin ascii = 8'h0D; mapped = 1'b1; end
         8'h66: begin ascii = 8'h08; mapped = 1'b1; end
         8'h76: begin ascii = 8'h1B; mapped = 1'b1; end
         8'h0D: begin ascii = 8'h09; mapped = 1'b1; end
         default: ;
      endcase
      if (lc != 8'h00) begin
         ascii  = upper ? (lc - 8'h20) : lc;
         mapped = 1'b1;
      end
   end

endmodule

// File: rtl/kbd_event_decoder.sv
// Turns raw PS/2 set-2 bytes into modifier-tagged ASCII key events in a FWFT FIFO.
// Latency: ps2_ready in S_IDLE -> kb_ready 3 cycles later; one byte per 3 cycles peak.
// Backpressure: no byte is popped from ps2_kbd while the event FIFO is full.
module kbd_event_decoder
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int EVT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       ps2_data,
   input  logic             ps2_ready,
   output logic             ps2_rdn,
   input  logic             kb_rd,
   output logic [EVT_W-1:0] kb_rdata,
   output logic             kb_ready,
   output logic             kb_full
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   state_t           state, state_nxt;
   logic [7:0]       byte_q;
   logic             brk_pend, ext_pend, shift_l, shift_r, ctrl, caps;
   logic             brk_nxt, ext_nxt, shl_nxt, shr_nxt, ctrl_nxt, caps_nxt;
   logic             push, pop;
   logic [EVT_W-1:0] evt;
   logic [7:0]       ascii;
   logic             mapped, use_ascii;

   logic [EVT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;

   scancode_to_ascii u_map (
      .code   (byte_q),
      .upper  ((shift_l | shift_r) ^ caps),
      .ascii  (ascii),
      .mapped (mapped)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state: only leave idle when a byte is waiting and an event slot is free
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (ps2_ready && !kb_full) state_nxt = S_POP;
         S_POP:   state_nxt = S_DEC;
         S_DEC:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign ps2_rdn = (state != S_POP);

   // Capture the head byte on the same edge that retires the pop strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 byte_q <= 8'h00;
      else if (state == S_POP) byte_q <= ps2_data;
   end

   // Classify the captured byte: prefixes, modifiers, dropped codes or a key event
   always_comb begin
      brk_nxt  = brk_pend;
      ext_nxt  = ext_pend;
      shl_nxt  = shift_l;
      shr_nxt  = shift_r;
      ctrl_nxt = ctrl;
      caps_nxt = caps;
      push     = 1'b0;
      if (state == S_DEC) begin
         if (byte_q == SC_BREAK) begin
            brk_nxt = 1'b1;
         end else if (byte_q == SC_EXT) begin
            ext_nxt = 1'b1;
         end else if (!is_dropped(byte_q)) begin
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
            case (byte_q)
               SC_LSHIFT: shl_nxt  = !brk_pend;
               SC_RSHIFT: shr_nxt  = !brk_pend;
               SC_CTRL:   ctrl_nxt = !brk_pend;
               SC_CAPS:   if (!brk_pend) caps_nxt = !caps;
               default:   push = 1'b1;
            endcase
         end
      end
   end

   // Event word; modifiers never change on a pushing byte, so current state is the updated state
   always_comb begin
      use_ascii      = mapped && !ext_pend;
      evt            = '0;
      evt[EVT_BRK]   = brk_pend;
      evt[EVT_EXT]   = ext_pend;
      evt[EVT_SHIFT] = shift_l | shift_r;
      evt[EVT_CTRL]  = ctrl;
      evt[EVT_CAPS]  = caps;
      evt[EVT_UNMAP] = !use_ascii;
      evt[7:0]       = use_ascii ? ascii : byte_q;
   end

   // Prefix and modifier state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         brk_pend <= 1'b0;
         ext_pend <= 1'b0;
         shift_l  <= 1'b0;
         shift_r  <= 1'b0;
         ctrl     <= 1'b0;
         caps     <= 1'b0;
      end else begin
         brk_pend <= brk_nxt;
         ext_pend <= ext_nxt;
         shift_l  <= shl_nxt;
         shift_r  <= shr_nxt;
         ctrl     <= ctrl_nxt;
         caps     <= caps_nxt;
      end
   end

   assign pop      = kb_rd && kb_ready;
   assign kb_ready = (count != '0);
   assign kb_full  = (count == CW'(FIFO_DEPTH));
   assign kb_rdata = kb_ready ? mem[rd_ptr] : '0;

   // Event storage; contents are don't-care until counted valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= evt;
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
